// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU memory stage: op codes, FSM state
// encodings and byte-count helpers. The optional feature is selected by
// the macro LSU_MISALIGN_TRAP_EN and is handled in lsu_mem_stage.sv.
package lsu_mem_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LBU      = 4'd4,
    LHU      = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_op_t;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [2:0] NB_BYTE = 3'd1;
  localparam logic [2:0] NB_HALF = 3'd2;
  localparam logic [2:0] NB_WORD = 3'd4;

  // Number of bytes moved by an op; 0 for non-memory and unknown codes.
  function automatic logic [2:0] op_nbytes(input logic [3:0] op);
    case (op)
      LB, LBU, SB: op_nbytes = NB_BYTE;
      LH, LHU, SH: op_nbytes = NB_HALF;
      LW, SW:      op_nbytes = NB_WORD;
      default:     op_nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    op_is_load = (op == LB) || (op == LH) || (op == LW) ||
                 (op == LBU) || (op == LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op == SB) || (op == SH) || (op == SW);
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_ext.sv
// Load extension: turns the little-endian assembled word into the final
// register value, sign- or zero-extending byte and halfword loads.
module lsu_load_ext
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  op,
  output logic [31:0] result
);

  // Select extension by load type; anything else passes the word through.
  always_comb begin
    result = word;
    case (op)
      LB:      result = {{24{word[7]}}, word[7:0]};
      LBU:     result = {24'h000000, word[7:0]};
      LH:      result = {{16{word[15]}}, word[15:0]};
      LHU:     result = {16'h0000, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage of the RV32I pipeline. Loads and stores are carried out as
// a sequence of byte accesses on the 8-bit memory port; the pipeline is
// stalled while an access is in flight and one registered write-back beat
// is produced per completing instruction.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// (adds the registered output misalign).
//
// Handshakes: in_valid is accepted in any cycle where rdy=1 and
// stall_req=0; while stall_req=1 upstream holds its inputs. On the memory
// port, mem_req/mem_wr/mem_addr/mem_wdata stay stable until the cycle in
// which mem_ack=1 (with rdy=1), which completes exactly one byte.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_sdata,
  input  logic [4:0]        in_waddr,
  input  logic              in_wreg,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              stall_req,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [XLEN-1:0]   wb_wdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [0:0]        state_dbg
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  logic [0:0]        state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] base_q;
  logic [XLEN-1:0]   sdata_q;
  logic [4:0]        rd_q;
  logic [1:0]        cnt;
  logic [31:0]       asm_q;
  logic [31:0]       asm_next;
  logic [31:0]       ext_res;
  logic              in_is_mem;
  logic              misal_in;
  logic              accept_mem;
  logic              in_access;
  logic              last;
  logic              store_q;

  assign in_is_mem = op_is_load(in_op) || op_is_store(in_op);
  assign in_access = (state == ST_ACCESS);
  assign store_q   = op_is_store(op_q);
  assign last      = ({1'b0, cnt} == (op_nbytes(op_q) - 3'd1));
  assign state_dbg = state;

  // Misalignment detection for the incoming instruction.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    misal_in = ((op_nbytes(in_op) == NB_HALF) && in_addr[0]) ||
               ((op_nbytes(in_op) == NB_WORD) && (in_addr[1:0] != 2'b00));
`else
    misal_in = 1'b0;
`endif
  end

  assign accept_mem = (state == ST_IDLE) && in_valid && in_is_mem && !misal_in;

  // Assembly word with the byte arriving this cycle merged in at lane cnt.
  always_comb begin
    asm_next = asm_q;
    asm_next[{cnt, 3'b000} +: 8] = mem_rdata;
  end

  lsu_load_ext u_load_ext (
    .word   (asm_next),
    .op     (op_q),
    .result (ext_res)
  );

  // Memory port drive and pipeline stall; request is suppressed while frozen.
  always_comb begin
    mem_req   = rdy && in_access;
    mem_wr    = in_access && store_q;
    mem_addr  = in_access ? (base_q + ADDR_W'(cnt)) : '0;
    mem_wdata = (in_access && store_q) ? sdata_q[{cnt, 3'b000} +: 8] : 8'h00;
    stall_req = !rdy || accept_mem || (in_access && !(mem_ack && last));
  end

  // FSM, latched instruction, byte counter and write-back register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= 4'd0;
      base_q   <= '0;
      sdata_q  <= '0;
      rd_q     <= 5'd0;
      cnt      <= 2'd0;
      asm_q    <= 32'd0;
      wb_we    <= 1'b0;
      wb_waddr <= 5'd0;
      wb_wdata <= '0;
    end else if (rdy) begin
      wb_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_mem) begin
            op_q    <= in_op;
            base_q  <= in_addr;
            sdata_q <= in_sdata;
            rd_q    <= in_waddr;
            cnt     <= 2'd0;
            asm_q   <= 32'd0;
            state   <= ST_ACCESS;
          end else if (in_valid && !in_is_mem) begin
            wb_we    <= in_wreg && (in_waddr != 5'd0);
            wb_waddr <= in_waddr;
            wb_wdata <= in_wdata;
          end
        end
        default: begin
          if (mem_ack) begin
            asm_q <= asm_next;
            if (last) begin
              state <= ST_IDLE;
              cnt   <= 2'd0;
              if (op_is_load(op_q)) begin
                wb_we    <= (rd_q != 5'd0);
                wb_waddr <= rd_q;
                wb_wdata <= ext_res;
              end
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // One-cycle misalignment pulse; the offending access is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (rdy) begin
      misalign <= (state == ST_IDLE) && in_valid && in_is_mem && misal_in;
    end
  end
`endif

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. Sits between the EX/MEM latch and the MEM/WB path into the register file write port (we/waddr/wdata).
- Executes loads and stores as sequences of byte accesses on the core's 8-bit memory-controller port.
- Stalls the pipeline while an access is in flight. Emits one registered write-back beat per instruction.

Parameters:
- ADDR_W, 32, width of in_addr and mem_addr.
- XLEN, 32, register and data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- rdy  in  1  chip ready; low freezes the block
- in_valid  in  1  instruction present from EX/MEM
- in_op  in  4  memory op code (package enum)
- in_addr  in  ADDR_W  effective address
- in_sdata  in  XLEN  store data (rs2)
- in_waddr  in  5  destination register
- in_wreg  in  1  instruction writes rd
- in_wdata  in  XLEN  ALU result for non-memory ops
- stall_req  out  1  upstream must hold its inputs
- wb_we  out  1  write-back enable
- wb_waddr  out  5  write-back register
- wb_wdata  out  XLEN  write-back data
- mem_req  out  1  byte access request
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid in the mem_ack cycle
- mem_ack  in  1  current byte done

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. After a reset edge: state IDLE; wb_we=0, wb_waddr=0, wb_wdata=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0; byte counter and assembly register cleared.
- Reset mid-access: aborts the access. No write-back and no further bytes are issued.
- rdy=0: all registers hold, mem_req is forced 0, mem_ack is ignored, stall_req=1.
- States: IDLE, ACCESS.
- IDLE, in_valid with MEM_NONE: registered pass-through. Next cycle wb_we=in_wreg & (in_waddr!=0), wb_wdata=in_wdata. stall_req=0. Latency 1.
- IDLE, in_valid with a load or store: latch op, address, store data and rd. Counter=0, go to ACCESS. stall_req=1 combinationally in this cycle. wb_we=0 next cycle.
- Byte count n: 1 for B/BU, 2 for H/HU, 4 for W.
- ACCESS:
  - mem_req=1, mem_addr=base+k, mem_wr=is_store, mem_wdata=sdata[8k+7:8k].
  - Signals stay stable until mem_ack.
  - On mem_ack for a read, mem_rdata is stored into assembly byte k (little-endian).
  - If k<n-1: k increments and the next byte is requested the following cycle.
  - If k==n-1: next cycle state=IDLE and mem_req=0. Loads pulse wb_we=(rd!=0) for one cycle with the extended value; stores keep wb_we=0.
- stall_req = (IDLE & in_valid & is_mem) | (ACCESS & ~(mem_ack & last)). It drops in the final ack cycle, so the next instruction is accepted in the cycle the load result appears.
- Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Address wrap: base+k wraps modulo 2^ADDR_W.
- wb_we is 0 on any cycle without a completing instruction (bubbles, stall cycles).
- Unknown op codes are treated as MEM_NONE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, registered).
  - An H/HU/SH access with addr[0]!=0, or a W/SW access with addr[1:0]!=0, issues no memory access and no write-back.
  - misalign pulses 1 for one cycle at latency 1, with stall_req=0.
- Not defined: misaligned accesses proceed bytewise like aligned ones. Port absent.

Decomposition:
- Shared package (defines file) holds:
  - op enum: MEM_NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8.
  - state encodings.
  - byte-count helper constants.
- One natural sub-module: lsu_load_ext. Combinational; takes the 32-bit assembled word and op, returns the extended result.

Test Plan:
- MEM_NONE, rd=5, wdata=0x1234, wreg=1 -> next cycle wb_we=1, wb_waddr=5, wb_wdata=0x1234; stall_req=0 throughout.
- LW addr 0x100, bytes 0x78,0x56,0x34,0x12 with ack each cycle -> four mem_req cycles at 0x100..0x103; then wb_wdata=0x12345678; stall_req falls in the 4th ack cycle.
- LB addr 0x3, rdata 0x80 -> wb_wdata=0xFFFFFF80. LBU of same -> 0x00000080. LH of 0x8001 -> 0xFFFF8001.
- SH addr 0x20, sdata 0xAABBCCDD, ack delayed 3 cycles per byte -> writes 0xDD@0x20 then 0xCC@0x21; addr/data stable while waiting; wb_we never 1.
- LW with rdy=0 for 2 cycles mid-access, then rst during the 3rd byte -> frozen while rdy=0 (mem_req=0); after reset all outputs 0 and no write-back.
- With LSU_MISALIGN_TRAP_EN: LW addr 0x102 -> misalign=1 next cycle, no mem_req, wb_we=0. Without the macro: the same access completes bytewise.
